// File: rtl/mux_scan.sv
// ---------------------------------------------------------------------------
// mux_scan -- registered N:1 channel multiplexer with manual select and
// automatic round-robin scan.
//
// The block works as a time-division channel sampler. In manual mode the
// channel named by sel is registered onto q every enabled cycle. In scan mode
// an internal pointer walks channels 0..CHANNELS-1. It spends DWELL enabled
// cycles on each channel, and din is re-sampled on every one of those cycles.
// The channel index travels with the data on ch. frame_start marks the first
// scan sample of channel 0.
//
// Parameters
//   WIDTH     bits per channel
//   CHANNELS  number of input channels (>= 2)
//   SEL_W     select / index width, 2**SEL_W >= CHANNELS
//   DWELL     enabled cycles spent on each channel while scanning (>= 1)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset, overrides en and mode
//   en           clock enable; all state and outputs hold while low
//   mode         0 = manual select, 1 = automatic scan
//   sel          manual channel select (ignored while scanning)
//   din          packed channel inputs, channel k at din[k*WIDTH +: WIDTH]
//   q            registered selected data
//   ch           index of the channel currently shown on q
//   frame_start  high while q carries the first scan sample of channel 0
//   sel_err      high while q reflects a manual sel >= CHANNELS
// ---------------------------------------------------------------------------
module mux_scan #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] din,
    output logic [WIDTH-1:0]          q,
    output logic [SEL_W-1:0]          ch,
    output logic                      frame_start,
    output logic                      sel_err
);

    // The dwell counter is always at least one bit wide. With DWELL == 1 it
    // simply stays at zero.
    localparam int DCNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    // Every select code has a slot. Codes past the last real channel read
    // zero, so the mux never indexes outside the array.
    localparam int SLOTS = 1 << SEL_W;

    localparam logic [SEL_W-1:0]  PTR_LAST  = SEL_W'(CHANNELS - 1);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DWELL - 1);

    // ------------------------------------------------------------------
    // Unpack the channel bus into one slot per select code.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] slot [SLOTS];

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            if (gi < CHANNELS) begin : g_used
                assign slot[gi] = din[gi*WIDTH +: WIDTH];
            end else begin : g_pad
                assign slot[gi] = '0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]  q_reg,    q_next;
    logic [SEL_W-1:0]  ch_reg,   ch_next;
    logic              fs_reg,   fs_next;
    logic              err_reg,  err_next;
    logic [SEL_W-1:0]  ptr_reg,  ptr_next;
    logic [DCNT_W-1:0] dcnt_reg, dcnt_next;

    // ------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------
    logic             sel_valid;
    logic             dwell_done;
    logic             frame_first;
    logic [SEL_W-1:0] ptr_adv;

    assign sel_valid   = (32'(sel) < CHANNELS);
    assign dwell_done  = (dcnt_reg == DCNT_LAST);
    assign frame_first = (ptr_reg == '0) && (dcnt_reg == '0);

    // The pointer wraps explicitly at the last real channel. This keeps it
    // in range when CHANNELS is not a power of two.
    assign ptr_adv = (ptr_reg == PTR_LAST) ? '0 : ptr_reg + 1'b1;

    // ------------------------------------------------------------------
    // Next-state logic. The clock enable is applied in the register stage.
    // ------------------------------------------------------------------
    always_comb begin
        q_next    = q_reg;
        ch_next   = ch_reg;
        fs_next   = fs_reg;
        err_next  = err_reg;
        ptr_next  = ptr_reg;
        dcnt_next = dcnt_reg;

        if (mode) begin
            // Scan: show the channel under the pointer, then advance the
            // dwell / pointer pair.
            q_next   = slot[ptr_reg];
            ch_next  = ptr_reg;
            fs_next  = frame_first;
            err_next = 1'b0;
            if (dwell_done) begin
                dcnt_next = '0;
                ptr_next  = ptr_adv;
            end else begin
                dcnt_next = dcnt_reg + 1'b1;
            end
        end else begin
            // Manual: the scan position is discarded, so the next entry
            // into scan mode always starts a fresh frame at channel 0.
            q_next    = sel_valid ? slot[sel] : '0;
            ch_next   = sel;
            fs_next   = 1'b0;
            err_next  = ~sel_valid;
            ptr_next  = '0;
            dcnt_next = '0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg    <= '0;
            ch_reg   <= '0;
            fs_reg   <= 1'b0;
            err_reg  <= 1'b0;
            ptr_reg  <= '0;
            dcnt_reg <= '0;
        end else if (en) begin
            q_reg    <= q_next;
            ch_reg   <= ch_next;
            fs_reg   <= fs_next;
            err_reg  <= err_next;
            ptr_reg  <= ptr_next;
            dcnt_reg <= dcnt_next;
        end
    end

    assign q           = q_reg;
    assign ch          = ch_reg;
    assign frame_start = fs_reg;
    assign sel_err     = err_reg;

endmodule

// File: tb/tb_mux_scan.sv
// ---------------------------------------------------------------------------
// tb_mux_scan -- self-checking bench for mux_scan.
//
// Three instances share the control inputs (rst, en, mode, sel):
//   a: WIDTH=1 CHANNELS=4 SEL_W=2 DWELL=1
//   b: WIDTH=4 CHANNELS=3 SEL_W=2 DWELL=3
//   c: WIDTH=8 CHANNELS=5 SEL_W=3 DWELL=2
// Each instance has its own din. Directed tasks compare against constant
// expectations. The random task compares against a reference model. The
// model counts scan samples since the last scan entry and derives the
// channel and frame marker arithmetically from that count.
// ---------------------------------------------------------------------------
module tb_mux_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, mode;
    logic [2:0]  sel;
    logic [3:0]  din_a;
    logic [11:0] din_b;
    logic [39:0] din_c;

    logic        q_a;
    logic [1:0]  ch_a;
    logic        fs_a, err_a;
    logic [3:0]  q_b;
    logic [1:0]  ch_b;
    logic        fs_b, err_b;
    logic [7:0]  q_c;
    logic [2:0]  ch_c;
    logic        fs_c, err_c;

    int errors = 0;
    int checks = 0;

    mux_scan #(.WIDTH(1), .CHANNELS(4), .SEL_W(2), .DWELL(1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel[1:0]), .din(din_a),
        .q(q_a), .ch(ch_a), .frame_start(fs_a), .sel_err(err_a)
    );

    mux_scan #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .DWELL(3)) dut_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel[1:0]), .din(din_b),
        .q(q_b), .ch(ch_b), .frame_start(fs_b), .sel_err(err_b)
    );

    mux_scan #(.WIDTH(8), .CHANNELS(5), .SEL_W(3), .DWELL(2)) dut_c (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .din(din_c),
        .q(q_c), .ch(ch_c), .frame_start(fs_c), .sel_err(err_c)
    );

    // ------------------------------------------------------------------
    // Reference model. m_k counts scan samples since scan entry. In scan
    // mode, sample k shows channel (k / DWELL) % CHANNELS. A frame begins
    // whenever k is a multiple of CHANNELS*DWELL.
    // ------------------------------------------------------------------
    int         m_k;
    logic       mq_a;
    logic [1:0] mch_a;
    logic       mfs_a, merr_a;
    logic [3:0] mq_b;
    logic [1:0] mch_b;
    logic       mfs_b, merr_b;
    logic [7:0] mq_c;
    logic [2:0] mch_c;
    logic       mfs_c, merr_c;

    always @(posedge clk) begin : model
        int s;
        int c;
        if (rst) begin
            m_k = 0;
            mq_a = '0; mch_a = '0; mfs_a = 1'b0; merr_a = 1'b0;
            mq_b = '0; mch_b = '0; mfs_b = 1'b0; merr_b = 1'b0;
            mq_c = '0; mch_c = '0; mfs_c = 1'b0; merr_c = 1'b0;
        end else if (en) begin
            if (!mode) begin
                m_k = 0;
                s = int'(sel[1:0]);
                mch_a = sel[1:0]; mfs_a = 1'b0;
                if (s < 4) begin mq_a = din_a[s]; merr_a = 1'b0; end
                else begin mq_a = 1'b0; merr_a = 1'b1; end
                mch_b = sel[1:0]; mfs_b = 1'b0;
                if (s < 3) begin mq_b = din_b[s*4 +: 4]; merr_b = 1'b0; end
                else begin mq_b = '0; merr_b = 1'b1; end
                s = int'(sel);
                mch_c = sel; mfs_c = 1'b0;
                if (s < 5) begin mq_c = din_c[s*8 +: 8]; merr_c = 1'b0; end
                else begin mq_c = '0; merr_c = 1'b1; end
            end else begin
                c = (m_k / 1) % 4;
                mq_a = din_a[c]; mch_a = c[1:0]; mfs_a = (m_k % 4 == 0); merr_a = 1'b0;
                c = (m_k / 3) % 3;
                mq_b = din_b[c*4 +: 4]; mch_b = c[1:0]; mfs_b = (m_k % 9 == 0); merr_b = 1'b0;
                c = (m_k / 2) % 5;
                mq_c = din_c[c*8 +: 8]; mch_c = c[2:0]; mfs_c = (m_k % 10 == 0); merr_c = 1'b0;
                m_k++;
            end
        end
    end

    // Apply the current inputs at the next rising edge, then sample
    // the outputs on the following falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; en = 1'b1; mode = 1'b1; sel = 3'd2;
        din_a = 4'hF; din_b = 12'hFFF; din_c = {40{1'b1}};
        cyc();
        cyc();
        checks++;
        if ({q_a, ch_a, fs_a, err_a} !== 5'b0) begin
            errors++;
            $display("FAIL reset_a: got q=%0h ch=%0d fs=%0b err=%0b, want all 0", q_a, ch_a, fs_a, err_a);
        end
        checks++;
        if ({q_b, ch_b, fs_b, err_b} !== 8'b0) begin
            errors++;
            $display("FAIL reset_b: got q=%0h ch=%0d fs=%0b err=%0b, want all 0", q_b, ch_b, fs_b, err_b);
        end
        checks++;
        if ({q_c, ch_c, fs_c, err_c} !== 13'b0) begin
            errors++;
            $display("FAIL reset_c: got q=%0h ch=%0d fs=%0b err=%0b, want all 0", q_c, ch_c, fs_c, err_c);
        end
        $display("reset: q_a=%0h ch_a=%0d q_b=%0h q_c=%0h", q_a, ch_a, q_b, q_c);
    endtask

    // ------------------------------------------------------------------
    task automatic test_manual();
        rst = 1'b0; mode = 1'b0; din_a = 4'b0100; sel = 3'd2;
        cyc();
        checks++;
        if (q_a !== 1'b1 || ch_a !== 2'd2) begin
            errors++;
            $display("FAIL manual_sel2: got q=%0h ch=%0d, want q=1 ch=2", q_a, ch_a);
        end
        $display("manual sel=2: q_a=%0h ch_a=%0d", q_a, ch_a);
        sel = 3'd1;
        cyc();
        checks++;
        if (q_a !== 1'b0 || ch_a !== 2'd1 || fs_a !== 1'b0 || err_a !== 1'b0) begin
            errors++;
            $display("FAIL manual_sel1: got q=%0h ch=%0d fs=%0b err=%0b, want q=0 ch=1 fs=0 err=0",
                     q_a, ch_a, fs_a, err_a);
        end
        $display("manual sel=1: q_a=%0h ch_a=%0d", q_a, ch_a);
    endtask

    // ------------------------------------------------------------------
    task automatic test_scan_dwell1();
        logic       eq;
        logic [1:0] ech;
        logic       efs;
        mode = 1'b1; din_a = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            cyc();
            eq  = (i % 2 == 1);
            ech = 2'(i % 4);
            efs = (i == 0) || (i == 4);
            checks++;
            if (q_a !== eq || ch_a !== ech || fs_a !== efs) begin
                errors++;
                $display("FAIL scan_dwell1[%0d]: got q=%0h ch=%0d fs=%0b, want q=%0h ch=%0d fs=%0b",
                         i, q_a, ch_a, fs_a, eq, ech, efs);
            end
            $display("scan dwell1 #%0d: q_a=%0h ch_a=%0d fs_a=%0b", i, q_a, ch_a, fs_a);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_scan_dwell3();
        logic [3:0] exp_q [10];
        logic [1:0] ech;
        logic       efs;
        exp_q = '{4'hA, 4'hA, 4'hA, 4'hB, 4'hB, 4'hB, 4'hC, 4'hC, 4'hC, 4'hA};
        mode = 1'b0;
        cyc();
        din_b = {4'hC, 4'hB, 4'hA};
        mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            ech = 2'((i / 3) % 3);
            efs = (i == 0) || (i == 9);
            checks++;
            if (q_b !== exp_q[i] || ch_b !== ech || fs_b !== efs) begin
                errors++;
                $display("FAIL scan_dwell3[%0d]: got q=%0h ch=%0d fs=%0b, want q=%0h ch=%0d fs=%0b",
                         i, q_b, ch_b, fs_b, exp_q[i], ech, efs);
            end
            $display("scan dwell3 #%0d: q_b=%0h ch_b=%0d fs_b=%0b", i, q_b, ch_b, fs_b);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_enable_hold();
        mode = 1'b0;
        cyc();
        din_b = 12'h321;
        mode = 1'b1;
        cyc();                              // sample 0: ch0, frame start
        // frame_start must stay high while the enable is low
        en = 1'b0;
        cyc();
        cyc();
        checks++;
        if (q_b !== 4'h1 || ch_b !== 2'd0 || fs_b !== 1'b1) begin
            errors++;
            $display("FAIL hold_frame: got q=%0h ch=%0d fs=%0b, want q=1 ch=0 fs=1", q_b, ch_b, fs_b);
        end
        $display("hold at frame start: q_b=%0h ch_b=%0d fs_b=%0b", q_b, ch_b, fs_b);
        en = 1'b1;
        cyc();                              // sample 1
        cyc();                              // sample 2
        cyc();                              // sample 3: first cycle of ch1
        checks++;
        if (q_b !== 4'h2 || ch_b !== 2'd1 || fs_b !== 1'b0) begin
            errors++;
            $display("FAIL pre_hold: got q=%0h ch=%0d fs=%0b, want q=2 ch=1 fs=0", q_b, ch_b, fs_b);
        end
        // Input changes while the enable is low must not reach q.
        en = 1'b0;
        din_b = 12'h654;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if (q_b !== 4'h2 || ch_b !== 2'd1 || fs_b !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: got q=%0h ch=%0d fs=%0b, want q=2 ch=1 fs=0", i, q_b, ch_b, fs_b);
            end
            $display("hold #%0d: q_b=%0h ch_b=%0d fs_b=%0b", i, q_b, ch_b, fs_b);
        end
        en = 1'b1;
        cyc();                              // sample 4: ch1 again
        checks++;
        if (q_b !== 4'h5 || ch_b !== 2'd1) begin
            errors++;
            $display("FAIL resume0: got q=%0h ch=%0d, want q=5 ch=1", q_b, ch_b);
        end
        din_b = 12'h0E0;                    // tracked inside the dwell
        cyc();                              // sample 5: last cycle of ch1
        checks++;
        if (q_b !== 4'hE || ch_b !== 2'd1) begin
            errors++;
            $display("FAIL resume1: got q=%0h ch=%0d, want q=e ch=1", q_b, ch_b);
        end
        cyc();                              // sample 6: ch2
        checks++;
        if (q_b !== 4'h0 || ch_b !== 2'd2) begin
            errors++;
            $display("FAIL resume2: got q=%0h ch=%0d, want q=0 ch=2", q_b, ch_b);
        end
        $display("resume: q_b=%0h ch_b=%0d fs_b=%0b", q_b, ch_b, fs_b);
    endtask

    // ------------------------------------------------------------------
    task automatic test_mode_switch_reset();
        din_a = 4'b1001;
        mode = 1'b0; sel = 3'd0;
        cyc();
        mode = 1'b1;
        cyc();
        cyc();
        cyc();
        checks++;
        if (ch_a !== 2'd2 || q_a !== 1'b0) begin
            errors++;
            $display("FAIL at_ch2: got q=%0h ch=%0d, want q=0 ch=2", q_a, ch_a);
        end
        mode = 1'b0; sel = 3'd3;
        cyc();
        checks++;
        if (q_a !== 1'b1 || ch_a !== 2'd3 || fs_a !== 1'b0) begin
            errors++;
            $display("FAIL to_manual: got q=%0h ch=%0d fs=%0b, want q=1 ch=3 fs=0", q_a, ch_a, fs_a);
        end
        $display("scan->manual: q_a=%0h ch_a=%0d", q_a, ch_a);
        mode = 1'b1;
        cyc();
        checks++;
        if (q_a !== 1'b1 || ch_a !== 2'd0 || fs_a !== 1'b1) begin
            errors++;
            $display("FAIL to_scan: got q=%0h ch=%0d fs=%0b, want q=1 ch=0 fs=1", q_a, ch_a, fs_a);
        end
        $display("manual->scan: q_a=%0h ch_a=%0d fs_a=%0b", q_a, ch_a, fs_a);
        cyc();                              // ch1
        rst = 1'b1;
        cyc();
        checks++;
        if ({q_a, ch_a, fs_a, err_a} !== 5'b0) begin
            errors++;
            $display("FAIL mid_reset: got q=%0h ch=%0d fs=%0b err=%0b, want all 0", q_a, ch_a, fs_a, err_a);
        end
        rst = 1'b0;
        cyc();
        checks++;
        if (ch_a !== 2'd0 || fs_a !== 1'b1 || q_a !== 1'b1) begin
            errors++;
            $display("FAIL restart0: got q=%0h ch=%0d fs=%0b, want q=1 ch=0 fs=1", q_a, ch_a, fs_a);
        end
        cyc();
        checks++;
        if (ch_a !== 2'd1 || fs_a !== 1'b0) begin
            errors++;
            $display("FAIL restart1: got ch=%0d fs=%0b, want ch=1 fs=0", ch_a, fs_a);
        end
        $display("after reset: q_a=%0h ch_a=%0d fs_a=%0b", q_a, ch_a, fs_a);
    endtask

    // ------------------------------------------------------------------
    task automatic test_sel_err();
        mode = 1'b0; sel = 3'd3; din_b = 12'hFFF;
        cyc();
        checks++;
        if (q_b !== 4'h0 || ch_b !== 2'd3 || err_b !== 1'b1) begin
            errors++;
            $display("FAIL sel_err_set: got q=%0h ch=%0d err=%0b, want q=0 ch=3 err=1", q_b, ch_b, err_b);
        end
        $display("sel=3 on 3 channels: q_b=%0h ch_b=%0d err_b=%0b", q_b, ch_b, err_b);
        sel = 3'd0;
        cyc();
        checks++;
        if (q_b !== 4'hF || ch_b !== 2'd0 || err_b !== 1'b0) begin
            errors++;
            $display("FAIL sel_err_clr: got q=%0h ch=%0d err=%0b, want q=f ch=0 err=0", q_b, ch_b, err_b);
        end
        $display("sel=0: q_b=%0h err_b=%0b", q_b, err_b);
        // Boundary on the five-channel instance: 5 is the first illegal code.
        din_c = 40'hA5_44_33_22_11;
        sel = 3'd5;
        cyc();
        checks++;
        if (q_c !== 8'h00 || ch_c !== 3'd5 || err_c !== 1'b1) begin
            errors++;
            $display("FAIL sel5_c: got q=%0h ch=%0d err=%0b, want q=0 ch=5 err=1", q_c, ch_c, err_c);
        end
        sel = 3'd4;
        cyc();
        checks++;
        if (q_c !== 8'hA5 || ch_c !== 3'd4 || err_c !== 1'b0) begin
            errors++;
            $display("FAIL sel4_c: got q=%0h ch=%0d err=%0b, want q=a5 ch=4 err=0", q_c, ch_c, err_c);
        end
        $display("sel=4 on 5 channels: q_c=%0h err_c=%0b", q_c, err_c);
    endtask

    // ------------------------------------------------------------------
    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            en  = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            sel   = 3'($urandom);
            din_a = 4'($urandom);
            din_b = 12'($urandom);
            din_c = {8'($urandom), 32'($urandom)};
            cyc();
            checks++;
            if ({q_a, ch_a, fs_a, err_a} !== {mq_a, mch_a, mfs_a, merr_a}) begin
                errors++;
                $display("FAIL rand_a[%0d]: got q=%0h ch=%0d fs=%0b err=%0b, want q=%0h ch=%0d fs=%0b err=%0b",
                         n, q_a, ch_a, fs_a, err_a, mq_a, mch_a, mfs_a, merr_a);
            end
            checks++;
            if ({q_b, ch_b, fs_b, err_b} !== {mq_b, mch_b, mfs_b, merr_b}) begin
                errors++;
                $display("FAIL rand_b[%0d]: got q=%0h ch=%0d fs=%0b err=%0b, want q=%0h ch=%0d fs=%0b err=%0b",
                         n, q_b, ch_b, fs_b, err_b, mq_b, mch_b, mfs_b, merr_b);
            end
            checks++;
            if ({q_c, ch_c, fs_c, err_c} !== {mq_c, mch_c, mfs_c, merr_c}) begin
                errors++;
                $display("FAIL rand_c[%0d]: got q=%0h ch=%0d fs=%0b err=%0b, want q=%0h ch=%0d fs=%0b err=%0b",
                         n, q_c, ch_c, fs_c, err_c, mq_c, mch_c, mfs_c, merr_c);
            end
            $display("rand #%0d rst=%0b en=%0b mode=%0b sel=%0d: a q=%0h ch=%0d | b q=%0h ch=%0d | c q=%0h ch=%0d",
                     n, rst, en, mode, sel, q_a, ch_a, q_b, ch_b, q_c, ch_c);
        end
        rst = 1'b0;
        en  = 1'b1;
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_manual();
        test_scan_dwell1();
        test_scan_dwell3();
        test_enable_hold();
        test_mode_switch_reset();
        test_sel_err();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, limit 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
